// File: rtl/fb_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid handshake with data memory,
// store lane formatting, load alignment/extension and pipeline stall.
module fb_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic [31:0] mem_alu_res,
  input  logic [31:0] mem_rs2_data,
  input  logic [31:0] mem_inst,
  output logic        dmem_req,
  input  logic        dmem_gnt,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        lsu_stall,
  output logic [31:0] lsu_rdata,
  output logic        lsu_exc
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP, DONE} state_t;

  state_t      state;
  logic        access;
  logic        is_store;
  logic [2:0]  funct3;
  logic [1:0]  off;
  logic        illegal;
  logic        misaligned;
  logic        start;
  logic [3:0]  be;
  logic [31:0] sh;
  logic [31:0] load_data;
  logic        unused_inst;

  assign access      = mem_mem_read | mem_mem_write;
  assign is_store    = mem_mem_write;
  assign funct3      = mem_inst[14:12];
  assign off         = mem_alu_res[1:0];
  assign unused_inst = ^{mem_inst[31:15], mem_inst[11:0]};

  always_comb begin
    illegal    = 1'b1;
    misaligned = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = is_store;
      default:                illegal = 1'b1;
    endcase
    case (funct3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign lsu_exc = access & (illegal | misaligned);
  assign start   = access & ~lsu_exc;

  // Request and stall are combinational so a fresh access is issued in IDLE.
  always_comb begin
    dmem_req  = 1'b0;
    lsu_stall = 1'b0;
    case (state)
      IDLE:     begin dmem_req = start; lsu_stall = start; end
      WAIT_GNT: begin dmem_req = 1'b1;  lsu_stall = 1'b1;  end
      WAIT_RSP: begin dmem_req = 1'b0;  lsu_stall = 1'b1;  end
      default:  begin dmem_req = 1'b0;  lsu_stall = 1'b0;  end
    endcase
  end

  assign dmem_we   = is_store;
  assign dmem_addr = {mem_alu_res[31:2], 2'b00};

  always_comb begin
    be         = 4'b1111;
    dmem_wdata = mem_rs2_data;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << off;
        dmem_wdata = {4{mem_rs2_data[7:0]}};
      end
      2'b01: begin
        be         = off[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{mem_rs2_data[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        dmem_wdata = mem_rs2_data;
      end
    endcase
  end

  assign dmem_be = is_store ? be : 4'b0000;
  assign sh      = dmem_rdata >> {off, 3'b000};

  always_comb begin
    case (funct3)
      3'b000:  load_data = {{24{sh[7]}}, sh[7:0]};
      3'b100:  load_data = {24'h0, sh[7:0]};
      3'b001:  load_data = {{16{sh[15]}}, sh[15:0]};
      3'b101:  load_data = {16'h0, sh[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  // rvalid only counts in WAIT_RSP, so stale responses after reset are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lsu_rdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= dmem_gnt ? WAIT_RSP : WAIT_GNT;
        end
        WAIT_GNT: begin
          if (dmem_gnt) state <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (dmem_rvalid) begin
            if (!is_store) lsu_rdata <= load_data;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
